// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch/decode/execute FSM producing Moore datapath strobes
// from the current state and IR, with single-step support and a sticky HALT state.
module control_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    i_clock,
  input  logic                    i_clear,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_mem_ready,
  input  logic [DATA_WIDTH-1:0]   i_ir,
  output logic                    o_pc_out,
  output logic                    o_zlow_out,
  output logic                    o_zhigh_out,
  output logic                    o_mdr_out,
  output logic                    o_mar_in,
  output logic                    o_z_in,
  output logic                    o_pc_in,
  output logic                    o_mdr_in,
  output logic                    o_ir_in,
  output logic                    o_y_in,
  output logic                    o_inc_pc,
  output logic                    o_read,
  output logic                    o_lo_in,
  output logic                    o_hi_in,
  output logic [REG_COUNT-1:0]    o_rin,
  output logic [REG_COUNT-1:0]    o_rout,
  output logic [OPCODE_WIDTH-1:0] o_alu_op,
  output logic                    o_done,
  output logic                    o_illegal,
  output logic                    o_halted,
  output logic [3:0]              o_state
);

  localparam int RW = $clog2(REG_COUNT);
  localparam int FIELD_LSB = DATA_WIDTH - OPCODE_WIDTH - 3*RW;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(5'b00011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(5'b00100);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(5'b00101);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5'b00110);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR  = OPCODE_WIDTH'(5'b00111);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL  = OPCODE_WIDTH'(5'b01001);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(5'b01111);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(5'b11011);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  state_t                  w_eoi;
  logic [OPCODE_WIDTH-1:0] w_op;
  logic [RW-1:0]           w_ra;
  logic [RW-1:0]           w_rb;
  logic [RW-1:0]           w_rc;
  logic                    w_alu_op;
  logic                    w_is_mul;

  assign w_op = i_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_ra = i_ir[DATA_WIDTH-OPCODE_WIDTH-1 -: RW];
  assign w_rb = i_ir[DATA_WIDTH-OPCODE_WIDTH-RW-1 -: RW];
  assign w_rc = i_ir[DATA_WIDTH-OPCODE_WIDTH-2*RW-1 -: RW];

  generate
    if (FIELD_LSB > 0) begin : g_spare
      logic w_unused_ir;
      assign w_unused_ir = ^i_ir[FIELD_LSB-1:0];
    end
  endgenerate

  assign w_is_mul = (w_op == OP_MUL);
  assign w_alu_op = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) ||
                    (w_op == OP_OR)  || (w_op == OP_SHR) || (w_op == OP_SHL) || w_is_mul;
  assign w_eoi    = (i_run && !i_step) ? S_T0 : S_IDLE;
  assign o_state  = r_state;

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Every output is decoded from r_state, so clear forces them low with no clock.
  always_comb begin
    w_next      = r_state;
    o_pc_out    = 1'b0;
    o_zlow_out  = 1'b0;
    o_zhigh_out = 1'b0;
    o_mdr_out   = 1'b0;
    o_mar_in    = 1'b0;
    o_z_in      = 1'b0;
    o_pc_in     = 1'b0;
    o_mdr_in    = 1'b0;
    o_ir_in     = 1'b0;
    o_y_in      = 1'b0;
    o_inc_pc    = 1'b0;
    o_read      = 1'b0;
    o_lo_in     = 1'b0;
    o_hi_in     = 1'b0;
    o_rin       = '0;
    o_rout      = '0;
    o_alu_op    = '0;
    o_done      = 1'b0;
    o_illegal   = 1'b0;
    o_halted    = 1'b0;
    case (r_state)
      S_IDLE: w_next = i_run ? S_T0 : S_IDLE;
      S_T0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_z_in   = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        o_zlow_out = 1'b1;
        o_pc_in    = 1'b1;
        o_read     = 1'b1;
        o_mdr_in   = 1'b1;
        w_next     = i_mem_ready ? S_T2 : S_T1;
      end
      S_T2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
        w_next    = S_T3;
      end
      S_T3: begin
        if (w_alu_op) begin
          o_rout = REG_COUNT'(1) << w_rb;
          o_y_in = 1'b1;
          w_next = S_T4;
        end else if (w_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          o_illegal = 1'b1;
          o_done    = 1'b1;
          w_next    = w_eoi;
        end
      end
      S_T4: begin
        o_rout   = REG_COUNT'(1) << w_rc;
        o_z_in   = 1'b1;
        o_alu_op = w_op;
        w_next   = S_T5;
      end
      S_T5: begin
        o_zlow_out = 1'b1;
        if (w_is_mul) begin
          o_lo_in = 1'b1;
          w_next  = S_T6;
        end else begin
          o_rin  = REG_COUNT'(1) << w_ra;
          o_done = 1'b1;
          w_next = w_eoi;
        end
      end
      S_T6: begin
        o_zhigh_out = 1'b1;
        o_hi_in     = 1'b1;
        o_done      = 1'b1;
        w_next      = w_eoi;
      end
      S_HALT: begin
        o_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
